// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM states,
// the captured-response record and the per-opcode latency lookup.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int CNT_W = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd3;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd4;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd5;
  localparam logic [OP_W-1:0] OP_AND  = 4'd6;
  localparam logic [OP_W-1:0] OP_OR   = 4'd7;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd8;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd9;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd10;
  localparam logic [OP_W-1:0] OP_LAST = OP_DIV;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // Everything handed back to the consumer alongside rsp_valid.
  typedef struct packed {
    logic [31:0] s;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        err;
  } rsp_t;

  // Codes above OP_LAST have no ALU function behind them.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_LAST;
  endfunction

  // Number of execute cycles the operands must be held on the ALU inputs.
  function automatic logic [CNT_W-1:0] op_latency(input logic [OP_W-1:0] op,
                                                  input int unsigned basic_cycles,
                                                  input int unsigned mul_cycles,
                                                  input int unsigned div_cycles);
    logic [CNT_W-1:0] lat;
    case (op)
      OP_MUL:  lat = CNT_W'(mul_cycles);
      OP_DIV:  lat = CNT_W'(div_cycles);
      default: lat = CNT_W'(basic_cycles);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last time.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot (or empty) grant, only while the scheduler can take work.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the branches leaves it unassigned and infers a latch.
    grant_o = 2'b00;
    if (enable_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters. A granted request's
// operands are registered onto the ALU and held for the opcode's multicycle
// window, then the result is captured and returned with a valid/ready
// handshake tagged with the owning requester.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned BASIC_CYCLES = 1,
  parameter int unsigned MUL_CYCLES   = 4,
  parameter int unsigned DIV_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_S,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_S,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_err
);

  state_e           state_q, state_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;

  logic [1:0]       grant;
  logic             sel;
  logic [OP_W-1:0]  sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  rr_arbiter2 u_arb (
    .req_i        ({req1_valid, req0_valid}),
    .enable_i     (state_q == IDLE),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // The arbiter grant is one-hot, so grant[1] alone picks the requester.
  assign sel    = grant[1];
  assign sel_op = sel ? req1_op : req0_op;
  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;

  // Next-state logic for the IDLE -> EXEC -> RESP issue cycle.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_d        = rsp_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_op_d     = sel_op;
          id_d         = sel;
          last_grant_d = sel;
          if (op_illegal(sel_op)) begin
            // No ALU work: the error response is prepared now and raised
            // from RESP one cycle later.
            rsp_d   = '{s: 32'd0, carry: 1'b0, overflow: 1'b0, zero: 1'b0, err: 1'b1};
            state_d = RESP;
          end else begin
            cnt_d   = op_latency(sel_op, BASIC_CYCLES, MUL_CYCLES, DIV_CYCLES) - CNT_W'(1);
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          rsp_d       = '{s: alu_S, carry: alu_carry, overflow: alu_overflow,
                          zero: alu_zero, err: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (!rsp_valid_q) begin
          // Only reached after an illegal opcode.
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
    end
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_control  = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_S        = rsp_q.s;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_err      = rsp_q.err;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU attached.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_A, alu_B;
  logic [3:0]  alu_control;
  logic [31:0] alu_S;
  logic        alu_carry, alu_overflow, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_S;
  logic        rsp_carry, rsp_overflow, rsp_zero, rsp_err;

  int errors = 0;
  int checks = 0;

  alu_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_control  (alu_control),
    .alu_S        (alu_S),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_S        (rsp_S),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    logic [32:0] sum;
    logic [63:0] prod;
    sum          = 33'd0;
    prod         = 64'd0;
    alu_S        = 32'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_control)
      4'd0: begin
        sum          = {1'b0, alu_A} + {1'b0, alu_B};
        alu_S        = sum[31:0];
        alu_carry    = sum[32];
        alu_overflow = (alu_A[31] == alu_B[31]) && (sum[31] != alu_A[31]);
      end
      4'd1: begin
        prod         = {32'd0, alu_A} * {32'd0, alu_B};
        alu_S        = prod[31:0];
        alu_overflow = |prod[63:32];
      end
      4'd2: begin
        alu_S     = alu_A - alu_B;
        alu_carry = alu_A < alu_B;
      end
      4'd3:  alu_S = alu_A << alu_B[4:0];
      4'd4:  alu_S = alu_A >> alu_B[4:0];
      4'd5:  alu_S = $signed(alu_A) >>> alu_B[4:0];
      4'd6:  alu_S = alu_A & alu_B;
      4'd7:  alu_S = alu_A | alu_B;
      4'd8:  alu_S = alu_A ^ alu_B;
      4'd9:  alu_S = ~(alu_A | alu_B);
      4'd10: alu_S = (alu_B == 32'd0) ? 32'hFFFF_FFFF : alu_A / alu_B;
      default: alu_S = 32'd0;
    endcase
    alu_zero = (alu_S == 32'd0);
  end

  task automatic drive_req(input int id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Called on the falling edge after the accept edge; returns how many
  // further falling edges pass until rsp_valid is seen (limit on timeout).
  task automatic wait_rsp(input int limit, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (alu_A !== 32'd0 || alu_B !== 32'd0) begin errors++; $display("FAIL reset_alu_ab: got %0h/%0h expected 0/0", alu_A, alu_B); end
    checks++; if (alu_control !== 4'd0) begin errors++; $display("FAIL reset_alu_control: got %0d expected 0", alu_control); end
    checks++; if ({rsp_S, rsp_id, rsp_carry, rsp_overflow, rsp_zero, rsp_err} !== 37'd0) begin errors++; $display("FAIL reset_rsp_fields: got S=%0h id=%0b flags=%0b%0b%0b%0b expected all 0", rsp_S, rsp_id, rsp_carry, rsp_overflow, rsp_zero, rsp_err); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b%0b expected 00", req1_ready, req0_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int cyc;
    @(negedge clk);
    drive_req(0, 4'd0, 32'd5, 32'd7);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready: got %0b%0b expected 01", req1_ready, req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (alu_A !== 32'd5 || alu_B !== 32'd7 || alu_control !== 4'd0) begin errors++; $display("FAIL add_alu_in: got %0d/%0d/%0d expected 5/7/0", alu_A, alu_B, alu_control); end
    wait_rsp(20, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", cyc); end
    checks++; if (rsp_S !== 32'd12) begin errors++; $display("FAIL add_S: got %0d expected 12", rsp_S); end
    checks++; if ({rsp_id, rsp_carry, rsp_zero, rsp_err} !== 4'b0000) begin errors++; $display("FAIL add_flags: got id/c/z/e=%0b%0b%0b%0b expected 0000", rsp_id, rsp_carry, rsp_zero, rsp_err); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_mul();
    int cyc;
    logic stable_ok;
    @(negedge clk);
    drive_req(1, 4'd1, 32'h0001_0000, 32'h0001_0000);
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL mul_ready: got %0b%0b expected 10", req1_ready, req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    req1_a     = 32'd0;
    req1_b     = 32'd0;
    stable_ok  = 1'b1;
    cyc        = 0;
    while (!rsp_valid && cyc < 20) begin
      if (alu_A !== 32'h0001_0000 || alu_B !== 32'h0001_0000 || alu_control !== 4'd1) stable_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL mul_alu_stable: got unstable expected held 10000/10000/1"); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL mul_latency: got %0d expected 4", cyc); end
    checks++; if (rsp_overflow !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL mul_ovf_id: got ovf=%0b id=%0b expected 1/1", rsp_overflow, rsp_id); end
    checks++; if (rsp_S !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL mul_S: got %0h z=%0b expected 0 z=1", rsp_S, rsp_zero); end
    checks++; if (alu_A !== 32'h0001_0000 || alu_control !== 4'd1) begin errors++; $display("FAIL mul_alu_hold_resp: got %0h/%0d expected 10000/1", alu_A, alu_control); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants[$];
    int gtime[$];
    logic [31:0] rs[$];
    int rid[$];
    @(negedge clk);
    drive_req(0, 4'd0, 32'd1, 32'd1);
    drive_req(1, 4'd0, 32'd2, 32'd2);
    for (int c = 0; c < 40 && rs.size() < 4; c++) begin
      #1;
      if (req0_ready) begin grants.push_back(0); gtime.push_back(c); end
      if (req1_ready) begin grants.push_back(1); gtime.push_back(c); end
      if (rsp_valid && rsp_ready) begin rs.push_back(rsp_S); rid.push_back(int'(rsp_id)); end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++; if (grants.size() !== 4 || rs.size() !== 4) begin errors++; $display("FAIL tie_counts: got grants=%0d rsps=%0d expected 4/4", grants.size(), rs.size()); end
    for (int i = 0; i < 4 && i < grants.size() && i < rs.size(); i++) begin
      checks++; if (grants[i] !== i % 2) begin errors++; $display("FAIL tie_grant%0d: got %0d expected %0d", i, grants[i], i % 2); end
      checks++; if (rs[i] !== ((i % 2) ? 32'd4 : 32'd2) || rid[i] !== i % 2) begin errors++; $display("FAIL tie_rsp%0d: got S=%0d id=%0d expected S=%0d id=%0d", i, rs[i], rid[i], (i % 2) ? 4 : 2, i % 2); end
      if (i > 0) begin
        checks++; if (gtime[i] - gtime[i-1] !== 3) begin errors++; $display("FAIL tie_spacing%0d: got %0d expected 3", i, gtime[i] - gtime[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    drive_req(0, 4'd2, 32'd3, 32'd3);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %0b expected 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    drive_req(1, 4'd0, 32'd9, 32'd9);
    wait_rsp(20, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", cyc); end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_S !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%0b S=%0d z=%0b id=%0b expected v=1 S=0 z=1 id=0", k, rsp_valid, rsp_S, rsp_zero, rsp_id); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_no_ready%0d: got %0b%0b expected 00", k, req1_ready, req0_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%0b r1=%0b expected v=0 r1=1", rsp_valid, req1_ready); end
    req1_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got %0b expected 0", req1_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || alu_A !== 32'd3) begin errors++; $display("FAIL bp_no_grant: got v=%0b A=%0d expected v=0 A=3", rsp_valid, alu_A); end
  endtask

  task automatic test_illegal();
    int cyc;
    @(negedge clk);
    drive_req(0, 4'd12, 32'hDEAD, 32'hBEEF);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got %0b expected 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(20, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ill_latency: got %0d expected 1", cyc); end
    checks++; if (rsp_err !== 1'b1 || rsp_S !== 32'd0) begin errors++; $display("FAIL ill_err: got err=%0b S=%0h expected err=1 S=0", rsp_err, rsp_S); end
    checks++; if ({rsp_carry, rsp_overflow, rsp_zero, rsp_id} !== 4'b0000) begin errors++; $display("FAIL ill_flags: got c/o/z/id=%0b%0b%0b%0b expected 0000", rsp_carry, rsp_overflow, rsp_zero, rsp_id); end
    @(negedge clk);
    drive_req(0, 4'd10, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(20, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL div_latency: got %0d expected 8", cyc); end
    checks++; if (rsp_S !== 32'd14 || rsp_err !== 1'b0) begin errors++; $display("FAIL div_S: got S=%0d err=%0b expected 14/0", rsp_S, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    int spurious;
    @(negedge clk);
    drive_req(0, 4'd10, 32'd50, 32'd5);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (alu_A !== 32'd0 || alu_B !== 32'd0 || alu_control !== 4'd0) begin errors++; $display("FAIL arst_alu: got %0h/%0h/%0d expected 0/0/0", alu_A, alu_B, alu_control); end
    @(negedge clk);
    rst_n    = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL arst_no_stale_rsp: got %0d valid cycles expected 0", spurious); end
    drive_req(0, 4'd0, 32'd1, 32'd2);
    drive_req(1, 4'd0, 32'd3, 32'd4);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL arst_tie: got %0b%0b expected 01", req1_ready, req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(20, cyc);
    checks++; if (cyc !== 1 || rsp_S !== 32'd3 || rsp_id !== 1'b0) begin errors++; $display("FAIL arst_first_op: got cyc=%0d S=%0d id=%0b expected 1/3/0", cyc, rsp_S, rsp_id); end
    @(negedge clk);
  endtask

  initial begin
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
